// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: register map and FSM states.
package uart_pkg;

  localparam logic [3:0] UartRegRxReady = 4'h0;
  localparam logic [3:0] UartRegRxData  = 4'h1;
  localparam logic [3:0] UartRegTxWrite = 4'h2;
  localparam logic [3:0] UartRegTxData  = 4'h3;
  localparam logic [3:0] UartRegTxReady = 4'h4;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_POLL,
    ARB_CHECK,
    ARB_WRITE,
    ARB_SETTLE
  } uart_arb_state_e;

  // Index of the requester after idx, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// CPU-side UART register port: address, write data, access strobe and registered read data.
interface uart_tx_arbiter_if #(
  parameter int unsigned DataBitsSize = 8
) ();

  logic [3:0]              uart_addr;
  logic [DataBitsSize-1:0] uart_wdata;
  logic                    uart_addr_strobe;
  logic [DataBitsSize-1:0] uart_data;

  modport master (
    output uart_addr,
    output uart_wdata,
    output uart_addr_strobe,
    input  uart_data
  );

  modport slave (
    input  uart_addr,
    input  uart_wdata,
    input  uart_addr_strobe,
    output uart_data
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module uart_rr_pick #(
  parameter  int unsigned NumReq = 2,
  localparam int unsigned PtrW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [PtrW-1:0]   ptr_i,
  output logic [NumReq-1:0] pick_o,
  output logic              valid_o
);

  logic [PtrW-1:0] idx;

  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = PtrW'((ptr_i + k) % NumReq);
      if (!valid_o && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART transmit register port between NumReq byte streams with round-robin
// fairness and an optional per-owner lock that keeps multi-byte messages contiguous.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NumReq       = 2,
  parameter int unsigned DataBitsSize = 8,
  parameter int unsigned SettleCycles = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NumReq-1:0]              req,
  input  logic [NumReq-1:0]              lock,
  input  logic [NumReq*DataBitsSize-1:0] byte_i,
  output logic [NumReq-1:0]              ack,
  output logic [NumReq-1:0]              grant,
  output logic                           busy,
  uart_tx_arbiter_if.master              uart
);

  localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntW = 4;

  uart_arb_state_e         state_q, state_d;
  logic [NumReq-1:0]       grant_q, grant_d;
  logic [PtrW-1:0]         ptr_q, ptr_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [3:0]              addr_q, addr_d;
  logic [DataBitsSize-1:0] wdata_q, wdata_d;

  logic [NumReq-1:0]       pick;
  logic                    pick_valid;
  logic                    owner_req;
  logic                    owner_lock;
  logic [DataBitsSize-1:0] owner_byte;
  logic [PtrW-1:0]         owner_next;
  logic                    strobe;
  logic                    unused_rdata_hi;

  uart_rr_pick #(
    .NumReq(NumReq)
  ) u_pick (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .pick_o (pick),
    .valid_o(pick_valid)
  );

  assign owner_req  = |(req & grant_q);
  assign owner_lock = |(lock & grant_q);

  always_comb begin
    owner_byte = '0;
    owner_next = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (grant_q[i]) begin
        owner_byte = byte_i[i*DataBitsSize +: DataBitsSize];
        owner_next = PtrW'(rr_next(i, NumReq));
      end
    end
  end

  // Address/data are registered so they hold between strobes; they are loaded on
  // entry to the state that strobes them, so POLL and WRITE present them directly.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strobe  = 1'b0;
    ack     = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_q == '0) begin
          if (pick_valid) begin
            grant_d = pick;
            addr_d  = UartRegTxReady;
            state_d = ARB_POLL;
          end
        end else if (!owner_lock) begin
          grant_d = '0;
        end else if (owner_req) begin
          addr_d  = UartRegTxReady;
          state_d = ARB_POLL;
        end
      end
      ARB_POLL: begin
        strobe  = 1'b1;
        state_d = ARB_CHECK;
      end
      ARB_CHECK: begin
        if (uart.uart_data[0]) begin
          addr_d  = UartRegTxData;
          wdata_d = owner_byte;
          state_d = ARB_WRITE;
        end else begin
          state_d = ARB_POLL;
        end
      end
      ARB_WRITE: begin
        strobe  = 1'b1;
        ack     = grant_q;
        cnt_d   = CntW'(SettleCycles);
        state_d = ARB_SETTLE;
      end
      ARB_SETTLE: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          ptr_d   = owner_next;
          state_d = ARB_IDLE;
          if (!owner_lock) begin
            grant_d = '0;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign grant                 = grant_q;
  assign busy                  = (state_q != ARB_IDLE);
  assign uart.uart_addr        = addr_q;
  assign uart.uart_wdata       = wdata_q;
  assign uart.uart_addr_strobe = strobe;
  assign unused_rdata_hi       = ^uart.uart_data[DataBitsSize-1:1];

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: transaction-level write scoreboard plus UART bus-rule monitor.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int unsigned NR = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned SC = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req, lock, ack, grant;
  logic [NR*DW-1:0]  byte_v;
  logic              busy;

  uart_tx_arbiter_if #(.DataBitsSize(DW)) bus ();

  uart_tx_arbiter #(
    .NumReq      (NR),
    .DataBitsSize(DW),
    .SettleCycles(SC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .lock  (lock),
    .byte_i(byte_v),
    .ack   (ack),
    .grant (grant),
    .busy  (busy),
    .uart  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Requester streams: bytes are presented in order, advancing on each ack.
  logic [DW-1:0] sbytes [NR][4];
  int unsigned   slen [NR];
  int unsigned   spos [NR];
  logic          slock [NR];
  logic          shold [NR];

  // Expected writes in order, encoded as (requester << 8) | byte.
  int exp_q[$];
  int stall_left = 0;
  int last_poll  = -100;
  int last_write = -100;
  logic last_ready = 1'b0;
  int n_polls  = 0;
  int n_writes = 0;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic monitor();
    logic       stb;
    logic [3:0] a;
    int         e;
    if (!rst_n) begin
      last_poll  = -100;
      last_write = -100;
      last_ready = 1'b0;
      check("ack_in_reset", int'(ack), 0);
      return;
    end
    stb = bus.uart_addr_strobe;
    a   = bus.uart_addr;
    if (cyc == last_poll + 1) last_ready = bus.uart_data[0];
    check("grant_onehot0", int'($countones(grant) <= 1), 1);
    if (stb) check("strobe_addr_legal", int'(a == UartRegTxReady || a == UartRegTxData), 1);
    if (stb && a == UartRegTxReady) begin
      n_polls++;
      if (last_poll > last_write) begin
        check("poll_retry_gap", cyc - last_poll, 2);
        check("poll_retry_after_not_ready", int'(last_ready), 0);
      end else if (last_write >= 0) begin
        check("settle_gap", int'(cyc - last_write >= int'(SC) + 2), 1);
      end
      last_poll = cyc;
    end
    if (stb && a == UartRegTxData) begin
      n_writes++;
      check("write_poll_spacing", cyc - last_poll, 2);
      check("write_ready_seen", int'(last_ready), 1);
      check("write_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("write_wdata", int'(bus.uart_wdata), e & 'hFF);
        check("write_grant", int'(grant), 1 << (e >> 8));
        check("write_ack", int'(ack), 1 << (e >> 8));
      end
      last_write = cyc;
    end else begin
      check("ack_quiet", int'(ack), 0);
    end
  endtask

  // UART model: ready result of a poll becomes visible the cycle after the strobe.
  task automatic uart_model();
    if (rst_n && bus.uart_addr_strobe && bus.uart_addr == UartRegTxReady) begin
      bus.uart_data = (stall_left > 0) ? '0 : DW'(1);
      if (stall_left > 0) stall_left--;
    end
  endtask

  task automatic feed(input bit advance);
    for (int i = 0; i < NR; i++) begin
      if (advance && rst_n && ack[i] && spos[i] < slen[i]) spos[i]++;
      req[i]  = (spos[i] < slen[i]);
      lock[i] = slock[i] && (spos[i] < slen[i] || shold[i]);
      byte_v[i*DW +: DW] = (spos[i] < slen[i]) ? sbytes[i][spos[i]] : '0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
    uart_model();
    feed(1'b1);
  endtask

  task automatic load(input int i, input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                      input logic [DW-1:0] b2, input int unsigned n, input logic lk,
                      input logic hold);
    sbytes[i][0] = b0;
    sbytes[i][1] = b1;
    sbytes[i][2] = b2;
    slen[i]  = n;
    spos[i]  = 0;
    slock[i] = lk;
    shold[i] = hold;
    feed(1'b0);
  endtask

  function automatic bit streams_done();
    for (int i = 0; i < NR; i++) if (spos[i] < slen[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int  n = 0;
    bit  done;
    done = (exp_q.size() == 0) && !busy && streams_done();
    while (!done && n < budget) begin
      tick();
      n++;
      done = (exp_q.size() == 0) && !busy && streams_done();
    end
    check(name, int'(done), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    for (int i = 0; i < NR; i++) begin
      slen[i] = 0; spos[i] = 0; slock[i] = 1'b0; shold[i] = 1'b0;
    end
    exp_q.delete();
    stall_left = 0;
    feed(1'b0);
    rst_n    = 1'b1;
    n_writes = 0;
    n_polls  = 0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_strobe"}, int'(bus.uart_addr_strobe), 0);
    check({name, "_addr"}, int'(bus.uart_addr), 0);
    check({name, "_wdata"}, int'(bus.uart_wdata), 0);
    check({name, "_ack"}, int'(ack), 0);
    check({name, "_grant"}, int'(grant), 0);
    check({name, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int n;
    int viol;
    int strobes;
    int acks0;
    rst_n = 1'b1;
    bus.uart_data = '0;
    for (int i = 0; i < NR; i++) begin
      slen[i] = 0; spos[i] = 0; slock[i] = 1'b0; shold[i] = 1'b0;
    end
    feed(1'b0);
    #1 rst_n = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;

    // Single byte with ready already set.
    load(0, 8'h41, 8'h00, 8'h00, 1, 1'b0, 1'b0);
    exp_q.push_back(8'h41);
    n = 0;
    do begin tick(); n++; end while (!bus.uart_addr_strobe && n < 10);
    check("t1_poll_latency", n, 1);
    check("t1_poll_addr", int'(bus.uart_addr), 4);
    tick();
    check("t1_check_no_strobe", int'(bus.uart_addr_strobe), 0);
    tick();
    check("t1_write_strobe", int'(bus.uart_addr_strobe), 1);
    check("t1_write_addr", int'(bus.uart_addr), 3);
    check("t1_write_data", int'(bus.uart_wdata), 'h41);
    check("t1_write_ack", int'(ack), 'b01);
    tick();
    check("t1_settle1_busy", int'(busy), 1);
    tick();
    check("t1_settle2_busy", int'(busy), 1);
    tick();
    check("t1_busy_drop", int'(busy), 0);
    check("t1_grant_released", int'(grant), 0);
    check("t1_addr_held", int'(bus.uart_addr), 3);

    // Tx-ready stall: three not-ready polls, then ready.
    n_polls = 0; n_writes = 0; stall_left = 3;
    load(0, 8'h5A, 8'h00, 8'h00, 1, 1'b0, 1'b0);
    exp_q.push_back(8'h5A);
    wait_idle("t2_completes", 80);
    check("t2_poll_count", n_polls, 4);
    check("t2_write_count", n_writes, 1);

    // Fairness: both requesters continuously pending, pointer starts at 0.
    do_reset();
    load(0, 8'hA0, 8'hA0, 8'h00, 2, 1'b0, 1'b0);
    load(1, 8'hB0, 8'hB0, 8'h00, 2, 1'b0, 1'b0);
    exp_q.push_back(8'hA0); exp_q.push_back('h100 | 8'hB0);
    exp_q.push_back(8'hA0); exp_q.push_back('h100 | 8'hB0);
    wait_idle("t3_completes", 200);
    check("t3_write_count", n_writes, 4);

    // Locked message "HI\n" from requester 1 while requester 0 waits.
    do_reset();
    load(1, 8'h48, 8'h49, 8'h0A, 3, 1'b1, 1'b0);
    tick();
    load(0, 8'h30, 8'h00, 8'h00, 1, 1'b0, 1'b0);
    exp_q.push_back('h100 | 8'h48); exp_q.push_back('h100 | 8'h49);
    exp_q.push_back('h100 | 8'h0A); exp_q.push_back(8'h30);
    viol = 0; n = 0;
    while (spos[1] < 3 && n < 200) begin
      if (grant != 2'b10) viol++;
      tick();
      n++;
    end
    check("t4_grant_held", viol, 0);
    wait_idle("t4_completes", 100);
    check("t4_write_count", n_writes, 4);

    // Locked owner with no request blocks others until lock drops.
    do_reset();
    load(1, 8'h61, 8'h00, 8'h00, 1, 1'b1, 1'b1);
    exp_q.push_back('h100 | 8'h61);
    n = 0;
    while (spos[1] < 1 && n < 40) begin tick(); n++; end
    check("t5_first_write", int'(spos[1]), 1);
    tick(); tick(); tick();
    load(0, 8'h70, 8'h00, 8'h00, 1, 1'b0, 1'b0);
    exp_q.push_back(8'h70);
    strobes = 0; acks0 = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.uart_addr_strobe) strobes++;
      if (ack[0]) acks0++;
    end
    check("t5_no_strobes", strobes, 0);
    check("t5_no_ack0", acks0, 0);
    check("t5_grant_kept", int'(grant), 'b10);
    shold[1] = 1'b0;
    feed(1'b0);
    wait_idle("t5_completes", 60);
    check("t5_write_count", n_writes, 2);

    // Reset in CHECK aborts the access and returns the pointer to 0.
    do_reset();
    load(0, 8'h11, 8'h00, 8'h00, 1, 1'b0, 1'b0);
    exp_q.push_back(8'h11);
    wait_idle("t6_first_completes", 40);
    load(1, 8'h22, 8'h00, 8'h00, 1, 1'b0, 1'b0);
    load(0, 8'h33, 8'h00, 8'h00, 1, 1'b0, 1'b0);
    tick();
    check("t6_poll_strobe", int'(bus.uart_addr_strobe), 1);
    check("t6_rr_pick", int'(grant), 'b10);
    tick();
    check("t6_in_check", int'(bus.uart_addr_strobe), 0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t6_async_reset");
    exp_q.delete();
    n_writes = 0;
    tick();
    tick();
    check("t6_req_still_pending", int'(req), 'b11);
    rst_n = 1'b1;
    exp_q.push_back(8'h33); exp_q.push_back('h100 | 8'h22);
    wait_idle("t6_restart_completes", 80);
    check("t6_write_count", n_writes, 2);

    check("exp_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Owns the UART peripheral's CPU-side register port (addr/wdata/data/addr_strobe).
- Shares the transmit path between NumReq byte-stream requesters, e.g. CPU store path, boot/debug monitor, trace logger.
- For each granted byte: polls tx-ready (reg 0x4) until set, writes the byte (reg 0x3), then waits a settle gap before the next poll.
- Round-robin fairness, with an optional per-requester lock so that multi-byte messages never interleave.

Parameters:
- NumReq, 2: number of requesters (2..8).
- DataBitsSize, 8: byte width; must match the UART.
- SettleCycles, 2: idle cycles after a write strobe before re-polling (1..15). Covers the tx ready-drop latency.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  NumReq  per-requester byte valid; hold high and stable until ack.
- lock  in  NumReq  owner keeps the grant across bytes while its bit is high.
- byte_i  in  NumReq*DataBitsSize  packed bytes; requester i uses slice [i*8 +: 8].
- ack  out  NumReq  one-cycle pulse; byte i has been handed to the UART.
- grant  out  NumReq  one-hot current owner; 0 when unowned.
- busy  out  1  high in any state other than IDLE.
- uart_addr  out  4  UART register index.
- uart_wdata  out  DataBitsSize  UART write data.
- uart_addr_strobe  out  1  UART access strobe; at most one cycle per access.
- uart_data  in  DataBitsSize  UART registered read data; valid the cycle after the strobe.

Behaviour:
- Reset values:
  - uart_addr_strobe=0, uart_addr=0, uart_wdata=0.
  - ack=0, grant=0, busy=0.
  - RR pointer=0, state=IDLE, settle counter=0.
  - Reset mid-operation aborts the access; no ack is issued.
- FSM states: IDLE, POLL, CHECK, WRITE, SETTLE.
- IDLE:
  - If unowned and any req is high: pick the first requester with req high, searching from the RR pointer upward with wrap. Latch it in grant, go to POLL.
  - If owned (lock held) and owner req is high: go to POLL.
  - If owned and owner req is low: stay in IDLE, still owned. Other requesters stay blocked until the owner's lock drops; then clear grant the same cycle.
- POLL: strobe=1, addr=0x4. Next state is CHECK.
- CHECK: strobe=0; sample uart_data[0].
  - 1: go to WRITE.
  - 0: go back to POLL, i.e. a strobe every other cycle.
  - No timeout.
- WRITE:
  - strobe=1, addr=0x3, wdata=owner's byte.
  - ack[owner]=1 this cycle only.
  - Load settle counter with SettleCycles. Go to SETTLE.
- SETTLE:
  - Decrement the counter each cycle.
  - At 0: set RR pointer to owner+1 (wrap at NumReq).
  - If owner lock is high: keep grant, go to IDLE.
  - Else: clear grant, go to IDLE.
- uart_addr/uart_wdata hold their last value when the strobe is low.
- The arbiter never accesses regs 0x0–0x2.
- Minimum cost per byte with ready already set: POLL, CHECK, WRITE, SETTLE×SettleCycles, IDLE = 3+SettleCycles+1 cycles.
- req deasserted by the owner before ack (protocol violation): the byte in flight is still written and acked.
- lock only affects the owner. A lock on a non-owner is ignored until it wins arbitration.
- Simultaneous requests: RR order applies; a requester that has just been served becomes lowest priority.

Decomposition:
- uart_pkg holds:
  - UART register index constants: UartRegRxReady=0x0, UartRegRxData=0x1, UartRegTxWrite=0x2, UartRegTxData=0x3, UartRegTxReady=0x4.
  - Enum uart_arb_state_e.
- Sub-module uart_rr_pick: combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot pick, valid.
  - Reusable for a future rx demux.

Test Plan:
- Single byte, ready=1 held: req[0]=1, byte 0x41, SettleCycles=2.
  - Expected: strobe addr 0x4, then addr 0x3 with wdata 0x41 two cycles later.
  - ack[0] pulses in the WRITE cycle.
  - busy drops 3 cycles after WRITE.
- Tx-ready stall: model UART returns ready=0 for 3 polls, then 1.
  - Expected: exactly 4 addr-0x4 strobes spaced 2 cycles apart, then one 0x3 write.
  - No ack before the write.
- Fairness: req[0] and req[1] high continuously, bytes 0xA0/0xB0, lock=0.
  - Expected: writes alternate 0xA0, 0xB0, 0xA0, 0xB0.
  - First write is from requester 0, since the pointer resets to 0.
- Lock: requester 1 sends "HI\n" with lock[1]=1 while req[0] is held.
  - Expected: 0x48, 0x49, 0x0A written consecutively; grant stays 2'b10 throughout.
  - Requester 0 is served only after lock[1] drops.
- Locked owner idle: lock[1]=1, req[1]=0 for 20 cycles, req[0]=1.
  - Expected: no strobes and no ack[0] during those 20 cycles.
  - After lock[1] drops, requester 0 is written.
- Reset mid-operation: assert rst_n=0 in CHECK.
  - Expected: all outputs 0 asynchronously, no ack, pointer=0.
  - After release, a pending req restarts cleanly from POLL.
